// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage and decode-side consumers:
// fetch FSM states, bubble encoding, MIPS field positions and PC helpers.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int A1_MSB    = 25;
  localparam int A1_LSB    = 21;
  localparam int A2_MSB    = 20;
  localparam int A2_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int AD_MSB    = 25;
  localparam int AD_LSB    = 0;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Purely combinational split of a 32-bit MIPS word into the fields latched by IF/ID.
module instr_field_split
  import fetch_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  op,
  output logic [4:0]  a1,
  output logic [4:0]  a2,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output logic [25:0] ad
);

  assign op    = instr[OP_MSB:OP_LSB];
  assign a1    = instr[A1_MSB:A1_LSB];
  assign a2    = instr[A2_MSB:A2_LSB];
  assign rd    = instr[RD_MSB:RD_LSB];
  assign funct = instr[FUNCT_MSB:FUNCT_LSB];
  assign imm   = instr[IMM_MSB:IMM_LSB];
  assign ad    = instr[AD_MSB:AD_LSB];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a req/ack fetch with wait states,
// holds one instruction in a buffer and presents it split into IF/ID fields.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] PC,
  output logic [31:0] PCADD4,
  output logic [5:0]  OP,
  output logic [4:0]  A1,
  output logic [4:0]  A2,
  output logic [4:0]  RD,
  output logic [5:0]  FUNCT,
  output logic [15:0] IMM,
  output logic [25:0] AD
);

  localparam logic [31:0] RESET_PC_W = word_align(RESET_PC);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  pend_pc;
  logic [31:0]  ibuf;
  logic [31:0]  ibuf_pc;
  logic         ibuf_valid;

  logic         consume;
  logic         can_issue;
  logic         req_int;
  logic         capture;
  logic [31:0]  target;
  logic [31:0]  out_word;
  logic         unused_rpc_lsb;

  assign consume        = ~stall;
  assign can_issue      = ~ibuf_valid | consume;
  assign target         = {redirect_pc[31:2], 2'b00};
  assign unused_rpc_lsb = ^redirect_pc[1:0];

  // Once a request is outstanding it is held until acknowledged.
  always_comb begin
    req_int = 1'b0;
    case (state)
      IDLE:    req_int = can_issue & ~redirect;
      BUSY:    req_int = 1'b1;
      DROP:    req_int = 1'b1;
      default: req_int = 1'b0;
    endcase
  end

  assign imem_req  = req_int & ~reset;
  assign imem_addr = pc;

  // Only a non-redirected ack in IDLE or BUSY delivers an instruction.
  assign capture = imem_req & imem_ack &
                   ((state == IDLE) | ((state == BUSY) & ~redirect));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC_W;
      pend_pc    <= '0;
      ibuf       <= NOP_INSTR;
      ibuf_pc    <= '0;
      ibuf_valid <= 1'b0;
    end else begin
      if (capture) begin
        ibuf    <= imem_rdata;
        ibuf_pc <= pc;
      end

      if (capture) begin
        ibuf_valid <= 1'b1;
      end else if (redirect | consume) begin
        ibuf_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (redirect) begin
            pc <= target;
          end else if (req_int) begin
            if (imem_ack) begin
              pc <= pc_inc(pc);
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (imem_ack) begin
            pc    <= redirect ? target : pc_inc(pc);
            state <= IDLE;
          end else if (redirect) begin
            pend_pc <= target;
            state   <= DROP;
          end
        end
        DROP: begin
          // A redirect coinciding with the ack is newer than pend_pc.
          if (imem_ack) begin
            pc    <= redirect ? target : pend_pc;
            state <= IDLE;
          end else if (redirect) begin
            pend_pc <= target;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fetch_valid = ibuf_valid;
  assign out_word    = ibuf_valid ? ibuf : NOP_INSTR;
  assign PC          = ibuf_valid ? ibuf_pc : 32'h0;
  assign PCADD4      = ibuf_valid ? pc_inc(ibuf_pc) : 32'h0;

  instr_field_split u_split (
    .instr (out_word),
    .op    (OP),
    .a1    (A1),
    .a2    (A2),
    .rd    (RD),
    .funct (FUNCT),
    .imm   (IMM),
    .ad    (AD)
  );

endmodule
